port_stream_bridge: RTL and testbench

//  Peripheral-side endpoint for one processor I/O port pair. Turns processor

---
 rtl/port_stream_bridge.sv | 124 ++++++++++++
 tb/tb_port_stream_bridge.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/port_stream_bridge.sv
// Processor I/O port endpoint: port writes -> buffered TX byte stream,
// RX byte stream -> held input byte, status byte and level irq.
module port_stream_bridge #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_strobe,
  input  logic [WIDTH-1:0] proc_out,
  input  logic             rd_strobe,
  input  logic             stat_rd_strobe,
  output logic [WIDTH-1:0] proc_in,
  output logic [7:0]       proc_status,
  output logic             irq,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    RX_IDLE,
    RX_HOLD
  } rx_state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_pend_q, wr_pend_d;
  logic             ovf_q, ovf_d;
  rx_state_e        rx_state_q;
  logic [WIDTH-1:0] proc_in_q;

  logic             full, empty, pop;
  logic             do_push, drop;
  logic [4:0]       cnt_x;
  logic [3:0]       cnt_sat;

  always_comb begin
    full    = (cnt_q == FULL_CNT);
    empty   = (cnt_q == '0);
    pop     = !empty && tx_ready;
    // a push into a full FIFO still lands if the head leaves this edge
    do_push = wr_pend_q && (!full || pop);
    drop    = wr_pend_q && full && !pop;

    wr_pend_d = wr_strobe;
    wr_ptr_d  = wr_ptr_q + AW'(do_push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);

    cnt_d = cnt_q;
    unique case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // a fresh overflow beats the clear-on-read
    ovf_d = (ovf_q && !stat_rd_strobe) || drop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      wr_pend_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      wr_pend_q <= wr_pend_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= proc_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      proc_in_q  <= '0;
    end else begin
      unique case (rx_state_q)
        RX_IDLE: begin
          if (rx_valid) begin
            proc_in_q  <= rx_data;
            rx_state_q <= RX_HOLD;
          end
        end
        RX_HOLD: begin
          if (rd_strobe) rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cnt_x   = 5'(cnt_q);
    cnt_sat = cnt_x[4] ? 4'hF : cnt_x[3:0];

    tx_valid = !empty;
    // unwritten RAM never reaches the port
    tx_data  = empty ? '0 : mem_q[rd_ptr_q];

    proc_in  = proc_in_q;
    rx_ready = (rx_state_q == RX_IDLE);
    irq      = (rx_state_q == RX_HOLD);

    proc_status = {cnt_sat, ovf_q, full, empty,
                   rx_state_q == RX_HOLD};
  end

endmodule

// File: tb/tb_port_stream_bridge.sv
// Scoreboard bench for port_stream_bridge: directed TX/RX
// vectors, queued expectations, negedge monitors.
module tb_port_stream_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_strobe = 1'b0;
  logic [7:0] proc_out = '0;
  logic       rd_strobe = 1'b0;
  logic       stat_rd_strobe = 1'b0;
  logic [7:0] proc_in;
  logic [7:0] proc_status;
  logic       irq;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] wq[$];

  port_stream_bridge #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .clk(clk),
    .reset(reset),
    .wr_strobe(wr_strobe),
    .proc_out(proc_out),
    .rd_strobe(rd_strobe),
    .stat_rd_strobe(stat_rd_strobe),
    .proc_in(proc_in),
    .proc_status(proc_status),
    .irq(irq),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // proc_out follows the strobe by one cycle, like the core's port reg
  task automatic do_writes();
    foreach (wq[i]) begin
      wr_strobe = 1'b1;
      if (i > 0) proc_out = wq[i-1];
      tick();
    end
    wr_strobe = 1'b0;
    proc_out  = wq[wq.size()-1];
    tick();
  endtask

  task automatic drain(input int n);
    tx_ready = 1'b1;
    repeat (n) tick();
    tx_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready) begin
      if (txq.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else chk("tx_data", {24'h0, tx_data}, {24'h0, txq.pop_front()});
    end
    if (reset && irq && rd_strobe) begin
      if (rxq.size() == 0) chk("rx_unexpected", {24'h0, proc_in}, 32'hFFFF_FFFF);
      else chk("proc_in_read", {24'h0, proc_in}, {24'h0, rxq.pop_front()});
    end
  end

  initial begin
    repeat (2) tick();
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    chk("rst_status", {24'h0, proc_status}, 32'h02);
    chk("rst_proc_in", {24'h0, proc_in}, 32'h0);
    reset = 1'b1;
    tick();

    // single write, no bypass
    wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    proc_out  = 8'hA5;
    chk("w1_no_bypass", {31'h0, tx_valid}, 32'h0);
    tick();
    chk("w1_tx_valid", {31'h0, tx_valid}, 32'h1);
    chk("w1_tx_data", {24'h0, tx_data}, 32'hA5);
    chk("w1_status", {24'h0, proc_status}, 32'h10);
    tick();
    chk("w1_stable", {24'h0, tx_data}, 32'hA5);
    txq.push_back(8'hA5);
    drain(1);
    chk("w1_empty", {24'h0, proc_status}, 32'h02);

    // overflow: fifth byte lost
    wq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    do_writes();
    chk("ovf_status", {24'h0, proc_status}, 32'h4C);
    chk("ovf_head", {24'h0, tx_data}, 32'h11);
    txq.push_back(8'h11);
    txq.push_back(8'h12);
    txq.push_back(8'h13);
    txq.push_back(8'h14);
    drain(4);
    chk("ovf_drained_valid", {31'h0, tx_valid}, 32'h0);
    chk("ovf_drained_status", {24'h0, proc_status}, 32'h0A);
    stat_rd_strobe = 1'b1;
    tick();
    stat_rd_strobe = 1'b0;
    chk("ovf_cleared", {24'h0, proc_status}, 32'h02);

    // RX hold-off
    rx_valid = 1'b1;
    rx_data  = 8'h3C;
    rxq.push_back(8'h3C);
    tick();
    chk("rx_proc_in", {24'h0, proc_in}, 32'h3C);
    chk("rx_irq", {31'h0, irq}, 32'h1);
    chk("rx_ready_low", {31'h0, rx_ready}, 32'h0);
    chk("rx_status", {24'h0, proc_status}, 32'h03);
    rx_data = 8'h7E;
    repeat (2) tick();
    chk("rx_held", {24'h0, proc_in}, 32'h3C);
    chk("rx_irq_held", {31'h0, irq}, 32'h1);
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    chk("rx_irq_clr", {31'h0, irq}, 32'h0);
    chk("rx_ready_back", {31'h0, rx_ready}, 32'h1);
    chk("rx_kept", {24'h0, proc_in}, 32'h3C);
    rxq.push_back(8'h7E);
    tick();
    rx_valid = 1'b0;
    chk("rx_second", {24'h0, proc_in}, 32'h7E);
    chk("rx_irq2", {31'h0, irq}, 32'h1);
    rd_strobe = 1'b1;
    tick();
    chk("rx_idle_rd", {31'h0, irq}, 32'h0);
    tick();
    rd_strobe = 1'b0;
    chk("rx_idle_rd_ign", {31'h0, rx_ready}, 32'h1);
    chk("rx_last_kept", {24'h0, proc_in}, 32'h7E);

    // full push + pop on the same edge
    wq = '{8'h21, 8'h22, 8'h23, 8'h24};
    do_writes();
    chk("pp_full", {24'h0, proc_status}, 32'h44);
    txq.push_back(8'h21);
    txq.push_back(8'h22);
    txq.push_back(8'h23);
    txq.push_back(8'h24);
    txq.push_back(8'h25);
    wr_strobe = 1'b1;
    tick();
    wr_strobe = 1'b0;
    proc_out  = 8'h25;
    tx_ready  = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("pp_status", {24'h0, proc_status}, 32'h44);
    chk("pp_head", {24'h0, tx_data}, 32'h22);
    drain(4);
    chk("pp_empty", {24'h0, proc_status}, 32'h02);

    // ovf clear racing a dropped push
    wq = '{8'h31, 8'h32, 8'h33, 8'h34};
    do_writes();
    wr_strobe = 1'b1;
    tick();
    wr_strobe      = 1'b0;
    proc_out       = 8'h35;
    stat_rd_strobe = 1'b1;
    tick();
    stat_rd_strobe = 1'b0;
    chk("race_ovf_kept", {24'h0, proc_status}, 32'h4C);
    stat_rd_strobe = 1'b1;
    tick();
    stat_rd_strobe = 1'b0;
    chk("race_ovf_clr", {24'h0, proc_status}, 32'h44);
    txq.push_back(8'h31);
    txq.push_back(8'h32);
    txq.push_back(8'h33);
    txq.push_back(8'h34);
    drain(4);
    chk("race_empty", {24'h0, proc_status}, 32'h02);

    // async reset mid-stream
    wq = '{8'h41, 8'h42, 8'h43};
    do_writes();
    chk("mr_status", {24'h0, proc_status}, 32'h30);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    rx_valid = 1'b0;
    chk("mr_irq", {31'h0, irq}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("ar_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("ar_tx_data", {24'h0, tx_data}, 32'h0);
    chk("ar_irq", {31'h0, irq}, 32'h0);
    chk("ar_rx_ready", {31'h0, rx_ready}, 32'h1);
    chk("ar_status", {24'h0, proc_status}, 32'h02);
    chk("ar_proc_in", {24'h0, proc_in}, 32'h0);
    txq.delete();
    rxq.delete();
    #2 reset = 1'b1;
    tick();
    wq = '{8'h66};
    do_writes();
    chk("post_rst_status", {24'h0, proc_status}, 32'h10);
    txq.push_back(8'h66);
    drain(1);

    tick();
    chk("txq_left", txq.size(), 32'h0);
    chk("rxq_left", rxq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
